fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer that owns the program counter and drives the instruction-memory request handshake. It arbitrates every PC update (sequential step, branch redirect, jump redirect, stall, end-of-program halt) and presents one valid fetched address per accepted instruction to decode. It sits between the core's decode/branch logic and the instruction memory, and replaces free-running PC increment with a handshake-aware controller.

## Interface
- PC_W, 10: PC and imem address width (byte address)
- RESET_PC, 0: PC value after reset
- PROG_END, 64: first out-of-program address; a next-PC ≥ PROG_END halts
- HALT_PC, 128: PC value parked in HALT
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  level; leaves IDLE
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address, equals pc
- imem_ack  in  1  memory accepts/returns the request this cycle
- stall  in  1  back-end cannot accept a new instruction
- branch_sel  in  1  taken branch for the last delivered instruction
- immediate  in  32  signed branch word offset
- jump  in  1  jump for the last delivered instruction
- instruction_25  in  26  jump target field
- pc  out  PC_W  current fetch PC
- last_pc  out  PC_W  address of the last delivered instruction
- instr_valid  out  1  one-cycle pulse: instruction at last_pc delivered
- halted  out  1  HALT state
- perf_fetch_cnt  out  16  delivered-instruction count (only with FETCH_CTRL_PERF_EN)

## Operation
- States: IDLE → FETCH → (HOLD ↔ FETCH) → HALT. HALT is exited only by reset.
- IDLE: imem_req=0; start=1 → FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. Once raised, imem_req and imem_addr are held stable until imem_ack; a request is never withdrawn.
- On imem_ack: compute next PC; if stall=1 → HOLD (req=0) else stay in FETCH (back-to-back).
- HOLD: imem_req=0; stall=0 → FETCH.
- Next-PC priority: pending branch > pending jump > pc+4.
- Branch target = last_pc + 4 + (immediate[PC_W-3:0] << 2), mod 2^PC_W (wrap). Jump target = {instruction_25[PC_W-3:0], 2'b00}.
- branch_sel/jump are captured into a one-entry pending-redirect register on any cycle outside HALT; a newer assertion overwrites an unconsumed one. Consumed at the next PC update.
- Wrong-path drop: an ack that coincides with or follows capture of a redirect, before that redirect is applied, gives instr_valid=0 and last_pc unchanged.
- Halt: next-PC ≥ PROG_END → pc=HALT_PC, state HALT, halted=1, imem_req=0; branch/jump/start/stall ignored.
- Reset asserted mid-request: all state cleared immediately; the outstanding memory access is abandoned (memory is reset together with this block).

## Timing
- Reset values: pc=RESET_PC, last_pc=RESET_PC, imem_req=0, instr_valid=0, halted=0, pending cleared, perf_fetch_cnt=0, state IDLE.
- start sampled at edge N → imem_req=1 from N+1.
- imem_ack at edge N → pc, last_pc, instr_valid updated at N+1; next request (if no stall) visible at N+1. Zero-wait memory sustains one instruction per cycle.
- Redirect captured at edge N is applied at the first ack at or after N+1.
- HOLD exit: stall low at edge N → imem_req=1 at N+1.

## Configuration
- FETCH_CTRL_PERF_EN defined: perf_fetch_cnt increments by 1 on every instr_valid pulse, saturates at 16'hFFFF, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared core package: state encoding enum (IDLE, FETCH, HOLD, HALT), PC step constant 4, default PROG_END/HALT_PC.
- One sub-module natural: fetch_next_pc (combinational target computation and priority selection); FSM, pending register and counters stay in fetch_ctrl.

## Test plan
- Reset, start=1, imem_ack tied 1 → imem_addr 0,4,8,… one per cycle; instr_valid each cycle; halted=1 and pc=128 after the fetch at 60.
- imem_ack delayed 3 cycles on address 8 → imem_req and imem_addr=8 stable 3 cycles, no instr_valid until ack.
- After delivering address 12, branch_sel=1, immediate=3 → acked fetch at 16 dropped; next delivered address 28.
- After delivering 20, jump=1, instruction_25=5 → next delivered address 20; branch_sel and jump together → branch wins.
- stall=1 across ack at address 4 → imem_req=0 until stall drops, then request at 8 next cycle.
- rst low while imem_req=1 → all outputs return to reset values asynchronously; perf_fetch_cnt (PERF_EN) equals instructions delivered before reset, then 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared state encoding and PC constants for the fetch sequencer.
package fetch_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALT} state_t;
  localparam int PC_STEP = 4;
  localparam int DEF_PROG_END = 64;
  localparam int DEF_HALT_PC = 128;
endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: redirect target computation and next-PC priority selection.
module fetch_next_pc
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int PROG_END = DEF_PROG_END
) (
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] last_pc,
  input  logic            branch_sel,
  input  logic [31:0]     immediate,
  input  logic            jump,
  input  logic [25:0]     instruction_25,
  input  logic            pend_valid,
  input  logic [PC_W-1:0] pend_target,
  output logic            cap,
  output logic [PC_W-1:0] cap_target,
  output logic [PC_W-1:0] next_pc,
  output logic            halt_next
);
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;
  logic            unused_hi;
  assign br_target  = last_pc + PC_W'(PC_STEP) + {immediate[PC_W-3:0], 2'b00};
  assign jmp_target = {instruction_25[PC_W-3:0], 2'b00};
  assign cap        = branch_sel | jump;
  assign cap_target = branch_sel ? br_target : jmp_target;
  assign next_pc    = pend_valid ? pend_target : pc + PC_W'(PC_STEP);
  // one extra bit so a PROG_END of 2^PC_W still compares correctly
  assign halt_next  = {1'b0, next_pc} >= (PC_W+1)'(PROG_END);
  assign unused_hi  = ^{immediate[31:PC_W-2], instruction_25[25:PC_W-2]};
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC owner and imem handshake sequencer; FETCH_CTRL_PERF_EN adds perf_fetch_cnt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int PC_W = 10,
  parameter int RESET_PC = 0,
  parameter int PROG_END = DEF_PROG_END,
  parameter int HALT_PC = DEF_HALT_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            stall,
  input  logic            branch_sel,
  input  logic [31:0]     immediate,
  input  logic            jump,
  input  logic [25:0]     instruction_25,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] last_pc,
  output logic            instr_valid,
  output logic            halted
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [15:0]     perf_fetch_cnt
`endif
);
  state_t          state, state_d;
  logic            pend_valid;
  logic [PC_W-1:0] pend_target;
  logic            cap, halt_next, acc, cap_en, deliver;
  logic [PC_W-1:0] cap_target, next_pc;

  fetch_next_pc #(.PC_W(PC_W), .PROG_END(PROG_END)) u_next (
    .pc(pc),
    .last_pc(last_pc),
    .branch_sel(branch_sel),
    .immediate(immediate),
    .jump(jump),
    .instruction_25(instruction_25),
    .pend_valid(pend_valid),
    .pend_target(pend_target),
    .cap(cap),
    .cap_target(cap_target),
    .next_pc(next_pc),
    .halt_next(halt_next)
  );

  // an ack is wrong-path while a redirect is pending or being captured
  always_comb begin
    imem_req  = state == FETCH;
    halted    = state == HALT;
    acc       = imem_req & imem_ack;
    cap_en    = cap & ~halted;
    deliver   = acc & ~pend_valid & ~cap;
    state_d   = (state == IDLE && start)  ? FETCH :
                (acc && halt_next)        ? HALT  :
                (acc && stall)            ? HOLD  :
                (state == HOLD && !stall) ? FETCH : state;
  end

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= PC_W'(RESET_PC);
      last_pc     <= PC_W'(RESET_PC);
      instr_valid <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= '0;
    end else begin
      state       <= state_d;
      instr_valid <= deliver;
      if (deliver) last_pc <= pc;
      if (acc) pc <= halt_next ? PC_W'(HALT_PC) : next_pc;
      if (cap_en) begin
        pend_valid  <= 1'b1;
        pend_target <= cap_target;
      end else if (acc) begin
        pend_valid  <= 1'b0;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_fetch_cnt <= '0;
    else if (deliver && perf_fetch_cnt != 16'hFFFF) perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random checks of fetch_ctrl against a behavioural model.
module tb_fetch_ctrl;
  logic        clk = 0, rst = 0, start = 0, imem_ack = 0, stall = 0, branch_sel = 0, jump = 0;
  logic [31:0] immediate = 0;
  logic [25:0] instruction_25 = 0;
  logic        imem_req, instr_valid, halted;
  logic [9:0]  imem_addr, pc, last_pc;
`ifdef FETCH_CTRL_PERF_EN
  logic [15:0] perf_fetch_cnt;
`endif
  int checks = 0, errors = 0;
  int imm_i = 0, j_i = 0;
  int m_mode, m_pc, m_last, m_valid, m_pend, m_tgt, m_cnt;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .stall(stall), .branch_sel(branch_sel), .immediate(immediate),
    .jump(jump), .instruction_25(instruction_25), .pc(pc), .last_pc(last_pc),
    .instr_valid(instr_valid), .halted(halted)
`ifdef FETCH_CTRL_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int wrap(int x);
    return ((x % 1024) + 1024) % 1024;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // mode: 0 idle, 1 requesting, 2 held by stall, 3 halted
  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_last = 0; m_valid = 0; m_pend = 0; m_tgt = 0; m_cnt = 0;
  endtask

  task automatic step_model();
    int acc, cap, nxt, old_last;
    if (m_mode == 3) begin m_valid = 0; return; end
    acc = (m_mode == 1 && imem_ack) ? 1 : 0;
    cap = (branch_sel || jump) ? 1 : 0;
    old_last = m_last;
    m_valid = (acc && !m_pend && !cap) ? 1 : 0;
    if (m_valid != 0) begin
      m_last = m_pc;
      if (m_cnt < 65535) m_cnt++;
    end
    if (acc != 0) begin
      nxt = (m_pend != 0) ? m_tgt : wrap(m_pc + 4);
      if (nxt >= 64) begin m_pc = 128; m_mode = 3; end
      else begin m_pc = nxt; m_mode = stall ? 2 : 1; end
    end else if (m_mode == 0 && start) m_mode = 1;
    else if (m_mode == 2 && !stall) m_mode = 1;
    if (cap != 0) begin
      m_pend = 1;
      m_tgt = branch_sel ? wrap(old_last + 4 + imm_i * 4) : wrap(j_i * 4);
    end else if (acc != 0) m_pend = 0;
  endtask

  always @(negedge clk) begin
    chk("imem_req", int'(imem_req), (m_mode == 1) ? 1 : 0);
    chk("imem_addr", int'(imem_addr), m_pc);
    chk("pc", int'(pc), m_pc);
    chk("last_pc", int'(last_pc), m_last);
    chk("instr_valid", int'(instr_valid), m_valid);
    chk("halted", int'(halted), (m_mode == 3) ? 1 : 0);
`ifdef FETCH_CTRL_PERF_EN
    chk("perf_fetch_cnt", int'(perf_fetch_cnt), m_cnt);
`endif
  end

  task automatic tick();
    @(posedge clk);
    if (rst) step_model();
    #2;
  endtask

  task automatic set_in(logic s, logic a, logic st, logic b, logic jp, int im, int jv);
    start = s; imem_ack = a; stall = st; branch_sel = b; jump = jp;
    imm_i = im; j_i = jv; immediate = 32'(im); instruction_25 = 26'(jv);
  endtask

  task automatic do_reset();
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1;
  endtask

  task automatic next_deliver(output int a);
    a = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (instr_valid) begin a = int'(last_pc); return; end
    end
  endtask

  task automatic reset_vals(string tag);
    chk({tag, "_pc"}, int'(pc), 0);
    chk({tag, "_last"}, int'(last_pc), 0);
    chk({tag, "_req"}, int'(imem_req), 0);
    chk({tag, "_valid"}, int'(instr_valid), 0);
    chk({tag, "_halted"}, int'(halted), 0);
`ifdef FETCH_CTRL_PERF_EN
    chk({tag, "_perf"}, int'(perf_fetch_cnt), 0);
`endif
  endtask

  initial begin
    int a;
    model_reset();
    // sequential run to halt
    do_reset();
    reset_vals("rst0");
    set_in(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      next_deliver(a);
      chk("seq_addr", a, 4 * i);
    end
    chk("seq_halted", int'(halted), 1);
    chk("seq_halt_pc", int'(pc), 128);
`ifdef FETCH_CTRL_PERF_EN
    chk("seq_perf", int'(perf_fetch_cnt), 16);
`endif
    // delayed ack at address 8
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    next_deliver(a); next_deliver(a);
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", int'(imem_req), 1);
      chk("wait_addr", int'(imem_addr), 8);
      chk("wait_valid", int'(instr_valid), 0);
    end
    imem_ack = 1;
    next_deliver(a);
    chk("wait_deliver", a, 8);
    // branch after 12
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) next_deliver(a);
    chk("br_pre", a, 12);
    set_in(1, 1, 0, 1, 0, 3, 0);
    tick();
    chk("br_drop16", int'(instr_valid), 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    next_deliver(a);
    chk("br_target", a, 28);
    // jump after 20, then branch beats jump
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) next_deliver(a);
    chk("jmp_pre", a, 20);
    set_in(1, 1, 0, 0, 1, 0, 5);
    tick();
    chk("jmp_drop", int'(instr_valid), 0);
    set_in(1, 1, 0, 0, 0, 0, 0);
    next_deliver(a);
    chk("jmp_target", a, 20);
    set_in(1, 1, 0, 1, 1, 3, 5);
    tick();
    set_in(1, 1, 0, 0, 0, 0, 0);
    next_deliver(a);
    chk("br_wins", a, 36);
    // stall across ack at 4
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    next_deliver(a);
    stall = 1;
    tick();
    chk("stall_valid", int'(instr_valid), 1);
    chk("stall_last", int'(last_pc), 4);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", int'(imem_req), 0);
      tick();
    end
    stall = 0;
    tick();
    chk("unstall_req", int'(imem_req), 1);
    chk("unstall_addr", int'(imem_addr), 8);
    // async reset with a request outstanding
    do_reset();
    set_in(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) next_deliver(a);
    imem_ack = 0;
    tick();
    chk("pre_rst_req", int'(imem_req), 1);
`ifdef FETCH_CTRL_PERF_EN
    chk("pre_rst_perf", int'(perf_fetch_cnt), 5);
`endif
    #1 rst = 0;
    model_reset();
    #1 reset_vals("arst");
    do_reset();
    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if (m_mode == 3 || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        set_in($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
               $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
               int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 20)));
        tick();
      end
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
